// File: rtl/fir_3tap_inverse.sv
// fir_3tap_inverse: deconvolves a 3-tap FIR output back to input samples via an 8-step restoring divider.
// Optional INV_FIR_ROUND_EN rounds the quotient to nearest instead of truncating.
module fir_3tap_inverse #(
  parameter int XW = 8,
  parameter int YW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [XW-1:0] H0,
  input  logic [XW-1:0] H1,
  input  logic [XW-1:0] H2,
  input  logic [YW-1:0] y_in,
  input  logic          y_valid,
  output logic          y_ready,
  input  logic          hist_clr,
  output logic [XW-1:0] x_out,
  output logic          x_valid,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, CALC, DIV, OUT} state_t;
  state_t state, state_nxt;
  logic [YW-1:0] yr;
  logic [XW-1:0] h0, h1, h2, x1, x2, r, lo, cval, r_nxt, lo_nxt, q, xo;
  logic [2*XW-1:0] p1, p2;
  logic [YW+1:0] acc;
  logic [XW:0] t;
  logic [$clog2(XW)-1:0] cnt;
  logic clamp, ge, neg, ov;
  assign y_ready = state == IDLE;
  always_comb begin
    p1 = {{XW{1'b0}}, h1} * {{XW{1'b0}}, x1};
    p2 = {{XW{1'b0}}, h2} * {{XW{1'b0}}, x2};
    acc = {2'b00, yr} - {{(YW+2-2*XW){1'b0}}, p1} - {{(YW+2-2*XW){1'b0}}, p2};
    neg = acc[YW+1];
    ov = acc[YW:0] >= {{(YW+1-2*XW){1'b0}}, h0, {XW{1'b0}}};
    t = {r, lo[XW-1]};
    ge = t >= {1'b0, h0};
    r_nxt = ge ? t[XW-1:0] - h0 : t[XW-1:0];
    lo_nxt = {lo[XW-2:0], ge};
`ifdef INV_FIR_ROUND_EN
    q = ({r_nxt, 1'b0} >= {1'b0, h0} && !(&lo_nxt)) ? lo_nxt + 1'b1 : lo_nxt;
`else
    q = lo_nxt;
`endif
    xo = clamp ? cval : q;
    state_nxt = state == IDLE ? (y_valid ? CALC : IDLE) :
                state == CALC ? DIV :
                state == DIV  ? (cnt == 0 ? OUT : DIV) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      yr <= '0;
      h0 <= '0;
      h1 <= '0;
      h2 <= '0;
      x1 <= '0;
      x2 <= '0;
      r <= '0;
      lo <= '0;
      cnt <= '0;
      clamp <= 1'b0;
      cval <= '0;
      x_out <= '0;
      x_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nxt;
      x_valid <= 1'b0;
      if (state == IDLE) begin
        if (hist_clr) begin
          x1 <= '0;
          x2 <= '0;
        end
        if (y_valid) begin
          yr <= y_in;
          h0 <= H0;
          h1 <= H1;
          h2 <= H2;
        end
      end
      // clamp decision is frozen here; the divider still runs so latency never varies
      if (state == CALC) begin
        r <= acc[2*XW-1:XW];
        lo <= acc[XW-1:0];
        clamp <= h0 == 0 || neg || ov;
        cval <= {XW{ov && !neg && h0 != 0}};
        cnt <= $clog2(XW)'(XW-1);
      end
      if (state == DIV) begin
        r <= r_nxt;
        lo <= lo_nxt;
        cnt <= cnt - 1'b1;
        if (cnt == 0) begin
          x_out <= xo;
          err <= clamp;
          x_valid <= 1'b1;
          x2 <= x1;
          x1 <= xo;
        end
      end
    end
  end
endmodule

// File: tb/tb_fir_3tap_inverse.sv
// tb_fir_3tap_inverse: directed checks of reconstruction, latency, clamping, history and reset abort.
module tb_fir_3tap_inverse;
  logic clk = 0, rst = 1, y_valid = 0, hist_clr = 0;
  logic [7:0] H0 = 0, H1 = 0, H2 = 0;
  logic [15:0] y_in = 0;
  logic y_ready, x_valid, err;
  logic [7:0] x_out;
  int checks = 0, errors = 0;

  fir_3tap_inverse dut (
    .clk(clk), .rst(rst), .H0(H0), .H1(H1), .H2(H2), .y_in(y_in), .y_valid(y_valid),
    .y_ready(y_ready), .hist_clr(hist_clr), .x_out(x_out), .x_valid(x_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One sample through the block; coefficients are scrambled and hist_clr pulsed while busy.
  task automatic run(input logic [7:0] a, b, c, input logic [15:0] y, input logic clr,
                     input int ex, input int ee, input string tag);
    int n, hit;
    @(negedge clk);
    H0 = a; H1 = b; H2 = c; y_in = y; y_valid = 1; hist_clr = clr;
    chk({tag, " ready"}, y_ready, 1);
    @(posedge clk);
    @(negedge clk);
    y_valid = 0; hist_clr = 1; H0 = 8'd77; H1 = 8'd99; H2 = 8'd55;
    n = 0; hit = -1;
    while (hit < 0 && n < 20) begin
      if (x_valid) hit = n;
      else begin
        @(negedge clk);
        n++;
        if (n == 5) hist_clr = 0;
      end
    end
    hist_clr = 0;
    chk({tag, " latency"}, hit, 9);
    chk({tag, " x_out"}, x_out, ex);
    chk({tag, " err"}, err, ee);
    @(negedge clk);
    chk({tag, " pulse"}, x_valid, 0);
    chk({tag, " ready back"}, y_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, v1, v2, p2, rdy3, xv;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst y_ready", y_ready, 1);
    chk("rst x_valid", x_valid, 0);
    chk("rst x_out", x_out, 0);
    chk("rst err", err, 0);

    run(10, 20, 30, 30, 0, 3, 0, "s1a");
    run(10, 20, 30, 70, 0, 1, 0, "s1b");
    run(10, 20, 30, 120, 0, 1, 0, "s1c");
    run(10, 20, 30, 70, 0, 2, 0, "s1d");
    run(10, 20, 30, 80, 0, 1, 0, "s2a");
    run(10, 20, 30, 120, 0, 4, 0, "s2b");
    run(10, 20, 30, 160, 0, 5, 0, "s2c");

    // back-to-back: second sample held while busy
    @(negedge clk);
    H0 = 10; H1 = 20; H2 = 30; y_in = 250; y_valid = 1;
    @(posedge clk);
    @(negedge clk);
    y_in = 230;
    pulses = 0; v1 = -1; v2 = -1; p2 = -1; rdy3 = -1;
    for (int n = 0; n < 30; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 3) rdy3 = y_ready;
      if (n == 11) y_valid = 0;
      if (x_valid) begin
        pulses++;
        if (pulses == 1) v1 = x_out;
        else begin v2 = x_out; p2 = n; end
      end
    end
    chk("busy ready", rdy3, 0);
    chk("busy pulses", pulses, 2);
    chk("busy first", v1, 3);
    chk("busy second", v2, 2);
    chk("busy second lat", p2, 20);

    run(0, 20, 30, 50, 0, 0, 1, "h0zero");
    run(1, 0, 0, 300, 1, 255, 1, "over");
    @(negedge clk);
    hist_clr = 1;
    @(negedge clk);
    hist_clr = 0;
    run(10, 20, 30, 30, 0, 3, 0, "after clr");
    run(1, 0, 0, 9, 0, 9, 0, "set9");
    run(10, 20, 0, 50, 0, 0, 1, "negative");
    run(10, 20, 30, 30, 1, 3, 0, "clr+valid");

    // reset during the 4th DIV cycle
    @(negedge clk);
    H0 = 10; H1 = 20; H2 = 30; y_in = 90; y_valid = 1;
    @(posedge clk);
    @(negedge clk);
    y_valid = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    #1;
    chk("abort ready", y_ready, 1);
    @(negedge clk);
    rst = 0;
    xv = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      xv += int'(x_valid);
    end
    chk("abort no pulse", xv, 0);
    chk("abort x_out", x_out, 0);
    chk("abort err", err, 0);

    run(10, 20, 30, 30, 0, 3, 0, "r1a");
    run(10, 20, 30, 70, 0, 1, 0, "r1b");
    run(10, 20, 30, 120, 0, 1, 0, "r1c");
    run(10, 20, 30, 70, 0, 2, 0, "r1d");
`ifdef INV_FIR_ROUND_EN
    run(10, 0, 0, 35, 0, 4, 0, "round");
`else
    run(10, 0, 0, 35, 0, 3, 0, "round");
`endif
    run(10, 0, 0, 2559, 0, 255, 0, "edge below");
    run(10, 0, 0, 2560, 0, 255, 1, "edge at");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
